mem_access_unit: RTL

//  Load/store front-end sitting directly upstream of DataMemory in the MEM stage. Accepts one

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU request/response channel plus the
// word-wide DataMemory port. slave = the unit itself, master = CPU + memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for DataMemory: one byte-addressed request at a time,
// big-endian lanes, read-modify-write for sub-word stores, extended load data.
module mem_access_unit #(
  parameter int ADDR_W = 7
) (
  input  logic               clock,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q,    state_d;
  logic              write_q,    write_d;
  logic [1:0]        size_q,     size_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        offset_q,   offset_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic              err_q,      err_d;
  logic [31:0]       rword_q,    rword_d;

  logic              req_err;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;

  always_comb begin
    req_err = (bus.req_size == 2'b11)
           || (bus.req_size == SZ_HALF && bus.req_addr[0])
           || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
           || (bus.req_addr[31:ADDR_W+2] != '0);
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    offset_d   = offset_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rword_d    = rword_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          offset_d   = bus.req_addr[1:0];
          addr_d     = bus.req_addr[ADDR_W+1:2];
          wdata_d    = bus.req_wdata;
          err_d      = req_err;
          if (req_err)                                     state_d = S_RESP;
          else if (bus.req_write && bus.req_size == SZ_WORD) state_d = S_WR;
          else                                             state_d = S_RD;
        end
      end
      S_RD: begin
        rword_d = bus.mem_rdata;
        state_d = write_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rword_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      offset_q   <= offset_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rword_q    <= rword_d;
    end
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24], half offset 0 in [31:16].
  always_comb begin
    lane_shift  = (size_q == SZ_HALF) ? (offset_q[1] ? 5'd0 : 5'd16) : {~offset_q, 3'b000};
    lane_word   = rword_q >> lane_shift;
    merged_word = wdata_q;
    load_data   = rword_q;
    case (size_q)
      SZ_BYTE: begin
        merged_word = (rword_q & ~(32'h0000_00FF << lane_shift))
                    | ({24'h0, wdata_q[7:0]} << lane_shift);
        load_data   = unsigned_q ? {24'h0, lane_word[7:0]}
                                 : {{24{lane_word[7]}}, lane_word[7:0]};
      end
      SZ_HALF: begin
        merged_word = (rword_q & ~(32'h0000_FFFF << lane_shift))
                    | ({16'h0, wdata_q[15:0]} << lane_shift);
        load_data   = unsigned_q ? {16'h0, lane_word[15:0]}
                                 : {{16{lane_word[15]}}, lane_word[15:0]};
      end
      default: begin
        merged_word = wdata_q;
        load_data   = rword_q;
      end
    endcase
  end

  // Strobes decode straight from state_q, so an async reset kills mem_write at once.
  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.mem_read    = (state_q == S_RD);
  assign bus.mem_write   = (state_q == S_WR);
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = (state_q == S_WR) ? merged_word : 32'h0;
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_err    = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata  = (state_q == S_RESP && !err_q && !write_q) ? load_data : 32'h0;

endmodule
